// File: rtl/data_memory_ctrl_pkg.sv
// rtl/data_memory_ctrl_pkg.sv - shared types and constants for the data-memory controller
package data_memory_ctrl_pkg;

    localparam int DMEM_DEPTH = 1024;
    localparam int REQ_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - request/response bundle between MEM stage and data memory
interface data_memory_ctrl_if
    import data_memory_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
);

    logic                  CS;
    logic                  iWE;
    logic [REQ_ADDR_W-1:0] iAddress;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;
    logic                  stall;
    logic                  addr_err;

    modport master (
        output CS, iWE, iAddress, wdata,
        input  rdata, rvalid, stall, addr_err
    );

    modport slave (
        input  CS, iWE, iAddress, wdata,
        output rdata, rvalid, stall, addr_err
    );

endinterface

// File: rtl/data_memory_ctrl_ram.sv
// rtl/data_memory_ctrl_ram.sv - data RAM array, synchronous write, registered read, no reset
module data_memory_ctrl_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - wait-stated data RAM controller: latches a request, stalls, completes with rvalid
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    data_memory_ctrl_if.slave   bus
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              addr_err_q, addr_err_d;
    logic              rd_seen_q, rd_seen_d;

    logic              in_range;
    logic              accept;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    assign in_range = (bus.iAddress[REQ_ADDR_W-1:ADDR_W] == '0);
    assign accept   = (state_q == ST_IDLE) && bus.CS && in_range;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        addr_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d   = bus.iAddress[ADDR_W-1:0];
                    we_d    = bus.iWE;
                    wdata_d = bus.wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? ST_BUSY : ST_DONE;
                end else if (bus.CS) begin
                    addr_err_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read is captured on the edge entering DONE; idx_d covers the zero-wait path straight from IDLE.
    assign ram_re    = !rst && (state_d == ST_DONE) && (state_q != ST_DONE) && !we_d;
    assign ram_we    = !rst && (state_q == ST_DONE) && we_q;
    assign rd_seen_d = rd_seen_q | ram_re;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            addr_err_q <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            addr_err_q <= addr_err_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    data_memory_ctrl_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .re_i    (ram_re),
        .raddr_i (idx_d),
        .rdata_o (ram_rdata)
    );

    // The RAM read register has no reset, so rdata reads as zero until the first read completes.
    assign bus.rdata    = rd_seen_q ? ram_rdata : '0;
    assign bus.rvalid   = (state_q == ST_DONE);
    assign bus.stall    = !rst && (accept || (state_q == ST_BUSY));
    assign bus.addr_err = addr_err_q;

endmodule
